sprite_draw_ctrl: RTL

//  Sequencer for the VGA draw datapath: accepts sprite-draw and screen-clear requests.

---
 rtl/sprite_draw_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_draw_ctrl.sv
// Sequencer for the VGA draw datapath: sprite draw and full-screen clear scans.
// Optional DRAW_ROM_PIPE_EN: x/y/plot/black registered one stage behind romAddr for sync-read ROMs.
module sprite_draw_ctrl #(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              drawReq,
  input  logic              clearReq,
  input  logic [4:0]        spriteSel,
  input  logic [3:0]        posSel,
  input  logic [1:0]        rowSel,
  input  logic [7:0]        xInit,
  input  logic [6:0]        yInit,
  output logic              drawAck,
  output logic [3:0]        xInitSel,
  output logic [1:0]        yInitSel,
  output logic              xInitLoad,
  output logic              yInitLoad,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [ADDR_W-1:0] romAddr,
  output logic [4:0]        memorySel,
  output logic              black,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  // state | meaning: IDLE wait for request | LOAD program xInit/yInit | SETTLE registers settle
  //   SCAN one pixel per cycle | DRAIN flush pixel pipe stage | FINISH done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SCAN, S_DRAIN, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic              clr_q;
  logic [4:0]        spr_q;
  logic [3:0]        xsel_q;
  logic [1:0]        ysel_q;
  logic [7:0]        col;
  logic [6:0]        row;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        box_w;
  logic [6:0]        box_h;
  logic              accept;
  logic              scanning;
  logic              last_row;
  logic              last_col;
  logic              last_px;
  logic [7:0]        px_x;
  logic [6:0]        px_y;
  logic              px_on;

  assign box_w    = clr_q ? 8'(SCREEN_W) : 8'(SPRITE_W);
  assign box_h    = clr_q ? 7'(SCREEN_H) : 7'(SPRITE_H);
  assign last_row = (row == box_h - 7'd1);
  assign last_col = (col == box_w - 8'd1);
  assign last_px  = last_row && last_col;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drawAck   = 1'b0;
    xInitLoad = 1'b0;
    yInitLoad = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    scanning  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (clearReq || drawReq) begin
          accept    = 1'b1;
          drawAck   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        xInitLoad = 1'b1;
        yInitLoad = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_SCAN;
      S_SCAN: begin
        scanning = 1'b1;
`ifdef DRAW_ROM_PIPE_EN
        if (last_px) state_nxt = S_DRAIN;
`else
        if (last_px) state_nxt = S_FINISH;
`endif
      end
      S_DRAIN: state_nxt = S_FINISH;
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clear jobs always start at the origin, so their select codes are forced to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_q  <= 1'b0;
      spr_q  <= '0;
      xsel_q <= '0;
      ysel_q <= '0;
    end else if (accept) begin
      clr_q  <= clearReq;
      spr_q  <= spriteSel;
      xsel_q <= clearReq ? 4'd0 : posSel;
      ysel_q <= clearReq ? 2'd0 : rowSel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (state == S_LOAD) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (scanning) begin
      if (last_px) begin
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else begin
        addr <= addr + ADDR_W'(1);
        if (last_row) begin
          row <= '0;
          col <= col + 8'd1;
        end else begin
          row <= row + 7'd1;
        end
      end
    end
  end

  assign px_x  = xInit + col;
  assign px_y  = yInit + row;
  assign px_on = ({1'b0, px_x} < 9'(SCREEN_W)) && ({1'b0, px_y} < 8'(SCREEN_H));

  assign romAddr   = addr;
  assign memorySel = busy ? spr_q  : 5'd0;
  assign xInitSel  = busy ? xsel_q : 4'd0;
  assign yInitSel  = busy ? ysel_q : 2'd0;

`ifdef DRAW_ROM_PIPE_EN
  // Black drops one cycle after FINISH is reached so it is already low back in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x     <= '0;
      y     <= '0;
      plot  <= 1'b0;
      black <= 1'b0;
    end else begin
      x     <= scanning ? px_x : 8'd0;
      y     <= scanning ? px_y : 7'd0;
      plot  <= scanning && px_on;
      black <= clr_q && busy && (state != S_FINISH);
    end
  end
`else
  assign x     = scanning ? px_x : 8'd0;
  assign y     = scanning ? px_y : 7'd0;
  assign plot  = scanning && px_on;
  assign black = clr_q && busy;
`endif

endmodule
